conv_window_gen: RTL and testbench

- Raster-to-window converter directly upstream of the four-lane 3x3 conv kernel.
- Accepts one signed pixel per cycle in raster order for an IMG_W x IMG_H map.
- Emits every valid 3x3 window, (IMG_W-2) x (IMG_H-2) in total, packed as the kernel expects.
- After the last window: one idle cycle, then a one-cycle map-done pulse that advances the kernel's channel phase.

---
 rtl/conv_window_gen_if.sv | 29 ++
 rtl/conv_window_gen.sv | 138 +++++++++++++
 tb/tb_conv_window_gen.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_window_gen_if.sv
// Pixel-in / 3x3-window-out bundle between the raster source, conv_window_gen and the conv kernel.
// oDbgState mirrors the window generator's FSM state (0 RUN, 1 GAP, 2 DONE, 3 FLUSH).
interface conv_window_gen_if #(
    parameter int WI = 8
);
    logic                 iPixValid;
    logic [WI-1:0]        iPixData;
    logic                 oPixReady;
    logic                 oWindowValid;
    logic [3*WI-1:0]      oWindowInRow1;
    logic [3*WI-1:0]      oWindowInRow2;
    logic [3*WI-1:0]      oWindowInRow3;
    logic                 oMapDone;
    logic [1:0]           oDbgState;

    // Handshake: a pixel transfers on a rising edge where iPixValid && oPixReady; the
    // source holds iPixData while oPixReady is low. oWindowValid has no back-pressure.
    modport slave (
        input  iPixValid, iPixData,
        output oPixReady, oWindowValid, oWindowInRow1, oWindowInRow2, oWindowInRow3,
               oMapDone, oDbgState
    );

    modport master (
        output iPixValid, iPixData,
        input  oPixReady, oWindowValid, oWindowInRow1, oWindowInRow2, oWindowInRow3,
               oMapDone, oDbgState
    );
endinterface

// File: rtl/conv_window_gen.sv
// Raster-to-3x3-window converter feeding the conv kernel; one window per accepted pixel once r,c >= 2.
// Optional CONV_WIN_REPLAY_EN: stores the frame and replays it internally for NPASS total passes.
module conv_window_gen #(
    parameter int WI    = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int NPASS = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    conv_window_gen_if.slave   pix_if
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_GAP   = 2'd1,
        S_DONE  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [WI-1:0]   r_lb1 [IMG_W];
    logic [WI-1:0]   r_lb2 [IMG_W];
    logic [3*WI-1:0] r_win_row1;
    logic [3*WI-1:0] r_win_row2;
    logic [3*WI-1:0] r_win_row3;
    logic            r_win_valid;

    logic            w_ready;
    logic            w_src_valid;
    logic [WI-1:0]   w_src_data;
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_last_pix;

`ifdef CONV_WIN_REPLAY_EN
    localparam int PW = (NPASS > 1) ? $clog2(NPASS) : 1;
    localparam int AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1;

    logic [PW-1:0] r_pass;
    logic [WI-1:0] r_fmem [IMG_W*IMG_H];
    logic [AW-1:0] w_addr;
    logic          w_last_pass;

    assign w_addr      = AW'(r_row) * AW'(IMG_W) + AW'(r_col);
    assign w_last_pass = (r_pass == PW'(NPASS - 1));
    // Pass 0 takes the upstream stream; later passes read back one stored pixel every cycle.
    assign w_ready     = (r_state == S_RUN) && (r_pass == '0);
    assign w_src_valid = (r_pass == '0) ? pix_if.iPixValid : 1'b1;
    assign w_src_data  = (r_pass == '0) ? pix_if.iPixData : r_fmem[w_addr];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_pass <= '0;
        end else if (r_state == S_FLUSH) begin
            r_pass <= w_last_pass ? '0 : r_pass + 1'b1;
        end
    end

    always_ff @(posedge iClk) begin
        if (w_accept && (r_pass == '0)) begin
            r_fmem[w_addr] <= pix_if.iPixData;
        end
    end
`else
    // NPASS only matters when the replay memory is built in.
    if (NPASS < 1) begin : g_npass_unused
    end

    assign w_ready     = (r_state == S_RUN);
    assign w_src_valid = pix_if.iPixValid;
    assign w_src_data  = pix_if.iPixData;
`endif

    assign w_accept   = (r_state == S_RUN) && w_src_valid;
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    assign w_last_pix = w_accept && w_col_last && w_row_last;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:   if (w_last_pix) w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_RUN;
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state     <= S_RUN;
            r_col       <= '0;
            r_row       <= '0;
            r_win_valid <= 1'b0;
            r_win_row1  <= '0;
            r_win_row2  <= '0;
            r_win_row3  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_win_valid <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
            if (w_accept) begin
                // New column enters on the right: {row r-2, row r-1, row r}.
                r_win_row1 <= {r_win_row1[2*WI-1:0], r_lb2[r_col]};
                r_win_row2 <= {r_win_row2[2*WI-1:0], r_lb1[r_col]};
                r_win_row3 <= {r_win_row3[2*WI-1:0], w_src_data};
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= w_src_data;
        end
    end

    assign pix_if.oPixReady     = w_ready;
    assign pix_if.oWindowValid  = r_win_valid;
    assign pix_if.oWindowInRow1 = r_win_row1;
    assign pix_if.oWindowInRow2 = r_win_row2;
    assign pix_if.oWindowInRow3 = r_win_row3;
    assign pix_if.oMapDone      = (r_state == S_FLUSH);
    assign pix_if.oDbgState     = r_state;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen (default build): ramp, throttled, 0x80 and mid-frame-reset frames.
module tb_conv_window_gen;
    localparam int WI    = 8;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int W     = 9 * WI;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_window_gen_if #(.WI(WI)) bus ();

    conv_window_gen #(
        .WI(WI), .IMG_W(IMG_W), .IMG_H(IMG_H), .NPASS(4)
    ) dut (
        .iClk   (clk),
        .iRst   (rst),
        .pix_if (bus)
    );

    int total = 0;
    int bad   = 0;
    int md_cnt = 0;
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (bus.oMapDone === 1'b1) md_cnt++;
    end

    function automatic logic [7:0] pv(input bit konst, input int r, input int c);
        int v;
        v = (r * IMG_W + c) % 256;
        return konst ? 8'h80 : v[7:0];
    endfunction

    function automatic logic [23:0] exp_row(input bit konst, input int r, input int c);
        return {pv(konst, r, c - 2), pv(konst, r, c - 1), pv(konst, r, c)};
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input bit konst, input bit throttle, input bit abort, output int nwin);
        int r;
        int c;
        bit ph;
        logic [W-1:0] e;
        nwin = 0;
        r = 0;
        c = 0;
        ph = 1'b0;
        while (r < IMG_H) begin
            if (throttle && ph) begin
                bus.iPixValid = 1'b0;
                step();
                chk("gap_valid", W'(bus.oWindowValid), W'(0));
                ph = 1'b0;
                continue;
            end
            ph = 1'b1;
            chk("ready", W'(bus.oPixReady), W'(1));
            bus.iPixValid = 1'b1;
            bus.iPixData  = pv(konst, r, c);
            if (r >= 2 && c >= 2)
                exp_q.push_back({exp_row(konst, r - 2, c), exp_row(konst, r - 1, c), exp_row(konst, r, c)});
            if (abort && r == 10 && c == 5) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                bus.iPixValid = 1'b0;
                chk("rst_valid", W'(bus.oWindowValid), W'(0));
                chk("rst_done", W'(bus.oMapDone), W'(0));
                chk("rst_ready", W'(bus.oPixReady), W'(1));
                chk("rst_state", W'(bus.oDbgState), W'(0));
                exp_q.delete();
                return;
            end
            step();
            bus.iPixValid = 1'b0;
            chk("win_valid", W'(bus.oWindowValid), W'(r >= 2 && c >= 2));
            if (r >= 2 && c >= 2) begin
                e = exp_q.pop_front();
                chk("window", {bus.oWindowInRow1, bus.oWindowInRow2, bus.oWindowInRow3}, e);
                if (bus.oWindowValid === 1'b1) nwin++;
            end
            if (!konst && r == 2 && c == 2) begin
                chk("first_row1", W'(bus.oWindowInRow1), W'(24'h000102));
                chk("first_row2", W'(bus.oWindowInRow2), W'(24'h1C1D1E));
                chk("first_row3", W'(bus.oWindowInRow3), W'(24'h38393A));
            end
            if (!konst && r == IMG_H - 1 && c == IMG_W - 1)
                chk("last_row3", W'(bus.oWindowInRow3), W'(24'h0D0E0F));
            c++;
            if (c == IMG_W) begin
                c = 0;
                r++;
            end
        end
        // T+1: last window out, input blocked; offer a pixel that must be ignored.
        chk("gap_ready", W'(bus.oPixReady), W'(0));
        chk("gap_state", W'(bus.oDbgState), W'(1));
        bus.iPixValid = 1'b1;
        bus.iPixData  = 8'hFF;
        step();
        chk("t2_valid", W'(bus.oWindowValid), W'(0));
        chk("t2_done", W'(bus.oMapDone), W'(0));
        chk("t2_ready", W'(bus.oPixReady), W'(0));
        step();
        chk("t3_done", W'(bus.oMapDone), W'(1));
        chk("t3_ready", W'(bus.oPixReady), W'(0));
        chk("t3_valid", W'(bus.oWindowValid), W'(0));
        bus.iPixValid = 1'b0;
        step();
        chk("t4_done", W'(bus.oMapDone), W'(0));
        chk("t4_ready", W'(bus.oPixReady), W'(1));
        chk("t4_valid", W'(bus.oWindowValid), W'(0));
    endtask

    initial begin
        int n;
        int md0;
        bus.iPixValid = 1'b0;
        bus.iPixData  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", W'(bus.oPixReady), W'(1));
        chk("rst_valid", W'(bus.oWindowValid), W'(0));
        chk("rst_done", W'(bus.oMapDone), W'(0));
        chk("rst_state", W'(bus.oDbgState), W'(0));
        rst = 1'b0;
        step();

        run_frame(1'b0, 1'b0, 1'b0, n);
        chk("ramp_nwin", W'(n), W'(676));

        run_frame(1'b0, 1'b1, 1'b0, n);
        chk("throttle_nwin", W'(n), W'(676));

        run_frame(1'b1, 1'b0, 1'b0, n);
        chk("signed_nwin", W'(n), W'(676));

        md0 = md_cnt;
        run_frame(1'b0, 1'b0, 1'b1, n);
        step();
        chk("abort_no_done", W'(md_cnt - md0), W'(0));
        run_frame(1'b0, 1'b0, 1'b0, n);
        chk("after_abort_nwin", W'(n), W'(676));
        chk("after_abort_done", W'(md_cnt - md0), W'(1));
        chk("md_total", W'(md_cnt), W'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
